// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio types: PCM FIFO controller states and default sizing
package audio_pkg;

  // Controller FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_FLUSH = 2'd2
  } pcm_state_t;

  // Default stream bytes per refill burst (legal range 1..255)
  localparam int unsigned DEF_BURST_LEN    = 16;
  // Default number of cycles the FIFO reset is held on a flush
  localparam int unsigned DEF_FLUSH_CYCLES = 4;

endpackage

// File: rtl/pcm_fifo_ctrl_if.sv
// rtl/pcm_fifo_ctrl_if.sv - stream source and audio FIFO signal bundle for pcm_fifo_ctrl
interface pcm_fifo_ctrl_if;

  // Stream source side
  logic       stream_en;
  logic       stream_valid;
  logic [7:0] stream_data;
  logic       stream_ack;

  // Audio FIFO side
  logic       fifo_full;
  logic       fifo_almost_empty;
  logic       fifo_write;
  logic [7:0] fifo_wrdata;
  logic       fifo_reset;

  // Controller view
  modport master (
    input  stream_en, stream_valid, stream_data, fifo_full, fifo_almost_empty,
    output stream_ack, fifo_write, fifo_wrdata, fifo_reset
  );

  // Environment view (stream source + FIFO)
  modport slave (
    output stream_en, stream_valid, stream_data, fifo_full, fifo_almost_empty,
    input  stream_ack, fifo_write, fifo_wrdata, fifo_reset
  );

endinterface

// File: rtl/pcm_fifo_ctrl.sv
// rtl/pcm_fifo_ctrl.sv - PCM audio FIFO feeder: CPU byte path, stream refill bursts, flush; PCM_FIFO_OVERRUN_STAT_EN adds overrun flag
module pcm_fifo_ctrl
  import audio_pkg::*;
#(
  parameter int unsigned BURST_LEN    = DEF_BURST_LEN,
  parameter int unsigned FLUSH_CYCLES = DEF_FLUSH_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cpu_write,
  input  logic [7:0]        i_cpu_wrdata,
  input  logic              i_flush_req,
  pcm_fifo_ctrl_if.master   bus,
`ifdef PCM_FIFO_OVERRUN_STAT_EN
  input  logic              i_overrun_clr,
  output logic              o_overrun,
`endif
  output logic              o_busy
);

  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FW-1:0] LP_FLAST = FW'(FLUSH_CYCLES - 1);
  localparam logic [8:0]    LP_BURST = 9'(BURST_LEN);

  pcm_state_t    r_state;
  logic [7:0]    r_cnt;
  logic [FW-1:0] r_fcnt;
  logic          r_cpu_pend;
  logic [7:0]    r_cpu_data;
  logic          r_write;
  logic [7:0]    r_wrdata;
  logic          r_fifo_reset;

  logic          w_cpu_grant;
  logic          w_stream_grant;
  logic          w_last_byte;

  // Arbiter: a pending CPU byte always wins; a flush request blocks every grant
  always_comb begin
    w_cpu_grant    = r_cpu_pend && (r_state != ST_FLUSH) && !i_flush_req;
    w_stream_grant = (r_state == ST_BURST) && bus.stream_en && bus.stream_valid &&
                     !bus.fifo_full && !r_cpu_pend && !i_flush_req;
    w_last_byte    = ({1'b0, r_cnt} + 9'd1) >= LP_BURST;
  end

  assign bus.stream_ack  = w_stream_grant;
  assign bus.fifo_write  = r_write;
  assign bus.fifo_wrdata = r_wrdata;
  assign bus.fifo_reset  = r_fifo_reset;
  assign o_busy          = (r_state != ST_IDLE) || r_cpu_pend;

  // Data path: CPU pending register and the registered FIFO write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cpu_pend <= 1'b0;
      r_cpu_data <= 8'h00;
      r_write    <= 1'b0;
      r_wrdata   <= 8'h00;
    end else begin
      r_write <= 1'b0;
      if (w_cpu_grant) begin
        // A CPU byte granted into a full FIFO is dropped here
        if (!bus.fifo_full) begin
          r_write  <= 1'b1;
          r_wrdata <= r_cpu_data;
        end
      end else if (w_stream_grant) begin
        r_write  <= 1'b1;
        r_wrdata <= bus.stream_data;
      end

      // A write landing in the grant cycle refills the slot with the new byte
      if (i_flush_req || (r_state == ST_FLUSH)) begin
        r_cpu_pend <= 1'b0;
      end else if (i_cpu_write) begin
        r_cpu_pend <= 1'b1;
        r_cpu_data <= i_cpu_wrdata;
      end else if (w_cpu_grant) begin
        r_cpu_pend <= 1'b0;
      end
    end
  end

  // Control FSM: refill bursts, flush sequencing and the registered FIFO reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 8'd0;
      r_fcnt       <= '0;
      r_fifo_reset <= 1'b1;
    end else begin
      r_fifo_reset <= 1'b0;
      if (i_flush_req) begin
        // Entering or restarting a flush abandons any burst in progress
        r_state      <= ST_FLUSH;
        r_fcnt       <= '0;
        r_cnt        <= 8'd0;
        r_fifo_reset <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bus.stream_en && bus.fifo_almost_empty && !bus.fifo_full) begin
              r_state <= ST_BURST;
              r_cnt   <= 8'd0;
            end
          end
          ST_BURST: begin
            if (w_stream_grant) begin
              r_cnt <= r_cnt + 8'd1;
            end
            if (!bus.stream_en || bus.fifo_full || (w_stream_grant && w_last_byte) ||
                ({1'b0, r_cnt} >= LP_BURST)) begin
              r_state <= ST_IDLE;
            end
          end
          ST_FLUSH: begin
            if (r_fcnt == LP_FLAST) begin
              r_state <= ST_IDLE;
            end else begin
              r_fcnt       <= r_fcnt + 1'b1;
              r_fifo_reset <= 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef PCM_FIFO_OVERRUN_STAT_EN
  logic r_overrun;

  // Sticky overrun: a discarded CPU byte sets it, and setting beats clearing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (w_cpu_grant && bus.fifo_full) begin
      r_overrun <= 1'b1;
    end else if (i_overrun_clr || i_flush_req) begin
      r_overrun <= 1'b0;
    end
  end

  assign o_overrun = r_overrun;
`endif

endmodule

// File: tb/tb_pcm_fifo_ctrl.sv
// tb/tb_pcm_fifo_ctrl.sv - scoreboard bench for pcm_fifo_ctrl
module tb_pcm_fifo_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_write = 1'b0;
  logic [7:0] cpu_wrdata = 8'h00;
  logic       flush_req = 1'b0;
  logic       busy;
`ifdef PCM_FIFO_OVERRUN_STAT_EN
  logic       overrun_clr = 1'b0;
  logic       overrun;
`endif

  pcm_fifo_ctrl_if bus();

  int errors = 0;
  int checks = 0;

  logic       s_ack, s_write, s_rst, s_busy;
  logic [7:0] s_data;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  pcm_fifo_ctrl #(.BURST_LEN(16), .FLUSH_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_cpu_write  (cpu_write),
    .i_cpu_wrdata (cpu_wrdata),
    .i_flush_req  (flush_req),
    .bus          (bus),
`ifdef PCM_FIFO_OVERRUN_STAT_EN
    .i_overrun_clr(overrun_clr),
    .o_overrun    (overrun),
`endif
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    cpu_write             = 1'b0;
    cpu_wrdata            = 8'h00;
    flush_req             = 1'b0;
    bus.stream_en         = 1'b0;
    bus.stream_valid      = 1'b0;
    bus.stream_data       = 8'h00;
    bus.fifo_full         = 1'b0;
    bus.fifo_almost_empty = 1'b0;
  endtask

  // Called at a negedge with inputs already set: sample mid-cycle, log writes, move to next negedge
  task automatic clk_cycle();
    #1;
    s_ack   = bus.stream_ack;
    s_write = bus.fifo_write;
    s_data  = bus.fifo_wrdata;
    s_rst   = bus.fifo_reset;
    s_busy  = busy;
    if (s_write) got_q.push_back(s_data);
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.stream_en = 1'b1; bus.stream_valid = 1'b1; bus.fifo_almost_empty = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    checks++; if (bus.fifo_write !== 1'b0) begin errors++; $display("FAIL reset_write got=%b exp=0", bus.fifo_write); end
    checks++; if (bus.fifo_wrdata !== 8'h00) begin errors++; $display("FAIL reset_wrdata got=%h exp=00", bus.fifo_wrdata); end
    checks++; if (bus.fifo_reset !== 1'b1) begin errors++; $display("FAIL reset_fifo_reset got=%b exp=1", bus.fifo_reset); end
    checks++; if (bus.stream_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", bus.stream_ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    clk_cycle(); clk_cycle();
    checks++; if (s_rst !== 1'b0) begin errors++; $display("FAIL reset_release_fifo_reset got=%b exp=0", s_rst); end
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy got=%b exp=0", s_busy); end
  endtask

  task automatic test_flush();
    int n_rst, n_busy;
    got_q.delete();
    flush_req = 1'b1; clk_cycle(); flush_req = 1'b0;
    n_rst = 0; n_busy = 0;
    for (int i = 0; i < 12; i++) begin
      clk_cycle();
      if (s_rst) n_rst++;
      if (s_busy) n_busy++;
    end
    checks++; if (n_rst !== 4) begin errors++; $display("FAIL flush_len got=%0d exp=4", n_rst); end
    checks++; if (n_busy !== 4) begin errors++; $display("FAIL flush_busy_len got=%0d exp=4", n_busy); end
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL flush_idle_busy got=%b exp=0", s_busy); end
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL flush_no_write got=%0d exp=0", got_q.size()); end
  endtask

  task automatic test_flush_restart();
    int n_rst;
    got_q.delete();
    n_rst = 0;
    flush_req = 1'b1; clk_cycle(); flush_req = 1'b0;
    clk_cycle(); if (s_rst) n_rst++;
    flush_req = 1'b1; clk_cycle(); if (s_rst) n_rst++;
    flush_req = 1'b0;
    cpu_write = 1'b1; cpu_wrdata = 8'h77; clk_cycle(); if (s_rst) n_rst++;
    cpu_write = 1'b0;
    for (int i = 0; i < 10; i++) begin
      clk_cycle();
      if (s_rst) n_rst++;
    end
    checks++; if (n_rst !== 6) begin errors++; $display("FAIL flush_restart_len got=%0d exp=6", n_rst); end
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL flush_cpu_ignored got=%0d exp=0", got_q.size()); end
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL flush_restart_busy got=%b exp=0", s_busy); end
  endtask

  task automatic test_burst();
    int acks;
    logic prev;
    logic [7:0] g, e;
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h40 + 8'(i));
    acks = 0;
    bus.stream_en = 1'b1; bus.stream_valid = 1'b1; bus.fifo_almost_empty = 1'b1; bus.stream_data = 8'h40;
    clk_cycle();
    prev = s_ack;
    bus.fifo_almost_empty = 1'b0;
    for (int c = 0; c < 30; c++) begin
      clk_cycle();
      checks++; if (s_write !== prev) begin errors++; $display("FAIL burst_latency cycle=%0d got=%b exp=%b", c, s_write, prev); end
      prev = s_ack;
      if (s_ack) begin acks++; bus.stream_data = 8'h40 + 8'(acks); end
    end
    checks++; if (acks !== 16) begin errors++; $display("FAIL burst_acks got=%0d exp=16", acks); end
    checks++; if (got_q.size() !== 16) begin errors++; $display("FAIL burst_writes got=%0d exp=16", got_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++; if (g !== e) begin errors++; $display("FAIL burst_data got=%h exp=%h", g, e); end
    end
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL burst_end_busy got=%b exp=0", s_busy); end
    idle_inputs(); clk_cycle();
  endtask

  task automatic test_priority();
    int acks;
    logic prev, stall_chk, g_cpu, sent;
    logic [7:0] g, e;
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(8'h80 + 8'(i));
    exp_q.push_back(8'hA5);
    for (int i = 6; i < 16; i++) exp_q.push_back(8'h80 + 8'(i));
    acks = 0; stall_chk = 1'b0; sent = 1'b0;
    bus.stream_en = 1'b1; bus.stream_valid = 1'b1; bus.fifo_almost_empty = 1'b1; bus.stream_data = 8'h80;
    clk_cycle();
    prev = s_ack;
    bus.fifo_almost_empty = 1'b0;
    for (int c = 0; c < 30; c++) begin
      cpu_write = (acks == 5) && !sent;
      if (cpu_write) cpu_wrdata = 8'hA5;
      clk_cycle();
      checks++; if (s_write !== prev) begin errors++; $display("FAIL prio_latency cycle=%0d got=%b exp=%b", c, s_write, prev); end
      g_cpu = stall_chk;
      if (stall_chk) begin
        checks++; if (s_ack !== 1'b0) begin errors++; $display("FAIL prio_stall got=%b exp=0", s_ack); end
      end
      stall_chk = cpu_write;
      if (cpu_write) sent = 1'b1;
      cpu_write = 1'b0;
      prev = s_ack || g_cpu;
      if (s_ack) begin acks++; bus.stream_data = 8'h80 + 8'(acks); end
    end
    checks++; if (acks !== 16) begin errors++; $display("FAIL prio_acks got=%0d exp=16", acks); end
    checks++; if (got_q.size() !== 17) begin errors++; $display("FAIL prio_writes got=%0d exp=17", got_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++; if (g !== e) begin errors++; $display("FAIL prio_data got=%h exp=%h", g, e); end
    end
    idle_inputs(); clk_cycle();
  endtask

  task automatic test_full();
    int acks;
    logic prev;
    logic [7:0] g, e;
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back(8'h20 + 8'(i));
    acks = 0;
    bus.stream_en = 1'b1; bus.stream_valid = 1'b1; bus.fifo_almost_empty = 1'b1; bus.stream_data = 8'h20;
    clk_cycle();
    prev = s_ack;
    bus.fifo_almost_empty = 1'b0;
    for (int c = 0; c < 20; c++) begin
      bus.fifo_full = (acks >= 5);
      clk_cycle();
      checks++; if (s_write !== prev) begin errors++; $display("FAIL full_latency cycle=%0d got=%b exp=%b", c, s_write, prev); end
      prev = s_ack;
      if (s_ack) begin acks++; bus.stream_data = 8'h20 + 8'(acks); end
    end
    checks++; if (acks !== 5) begin errors++; $display("FAIL full_acks got=%0d exp=5", acks); end
    checks++; if (got_q.size() !== 5) begin errors++; $display("FAIL full_writes got=%0d exp=5", got_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++; if (g !== e) begin errors++; $display("FAIL full_data got=%h exp=%h", g, e); end
    end
    got_q.delete();
    cpu_write = 1'b1; cpu_wrdata = 8'h3C; clk_cycle(); cpu_write = 1'b0;
    for (int i = 0; i < 6; i++) clk_cycle();
    checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL full_cpu_discard got=%0d exp=0", got_q.size()); end
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL full_busy got=%b exp=0", s_busy); end
`ifdef PCM_FIFO_OVERRUN_STAT_EN
    #1;
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got=%b exp=1", overrun); end
    @(negedge clk);
    overrun_clr = 1'b1; clk_cycle(); overrun_clr = 1'b0; #1;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clr got=%b exp=0", overrun); end
    @(negedge clk);
`endif
    idle_inputs(); clk_cycle();
  endtask

  task automatic test_back_to_back();
    logic [7:0] g, e;
    got_q.delete(); exp_q.delete();
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    cpu_write = 1'b1; cpu_wrdata = 8'h11; clk_cycle();
    cpu_write = 1'b1; cpu_wrdata = 8'h22; clk_cycle();
    cpu_write = 1'b0;
    checks++; if (s_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got=%b exp=1", s_busy); end
    for (int i = 0; i < 5; i++) clk_cycle();
    checks++; if (got_q.size() !== 2) begin errors++; $display("FAIL b2b_writes got=%0d exp=2", got_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      checks++; if (g !== e) begin errors++; $display("FAIL b2b_data got=%h exp=%h", g, e); end
    end
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got=%b exp=0", s_busy); end
  endtask

  task automatic test_reset_mid_burst();
    int acks, acks_after, n_before;
    got_q.delete();
    acks = 0;
    bus.stream_en = 1'b1; bus.stream_valid = 1'b1; bus.fifo_almost_empty = 1'b1; bus.stream_data = 8'h60;
    clk_cycle();
    bus.fifo_almost_empty = 1'b0;
    for (int c = 0; c < 30 && acks < 7; c++) begin
      clk_cycle();
      if (s_ack) begin acks++; bus.stream_data = 8'h60 + 8'(acks); end
    end
    checks++; if (acks !== 7) begin errors++; $display("FAIL rstmid_reach got=%0d exp=7", acks); end
    n_before = got_q.size();
    rst = 1'b1; #1;
    checks++; if (bus.fifo_write !== 1'b0) begin errors++; $display("FAIL rstmid_write got=%b exp=0", bus.fifo_write); end
    checks++; if (bus.fifo_wrdata !== 8'h00) begin errors++; $display("FAIL rstmid_wrdata got=%h exp=00", bus.fifo_wrdata); end
    checks++; if (bus.fifo_reset !== 1'b1) begin errors++; $display("FAIL rstmid_fifo_reset got=%b exp=1", bus.fifo_reset); end
    checks++; if (bus.stream_ack !== 1'b0) begin errors++; $display("FAIL rstmid_ack got=%b exp=0", bus.stream_ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    acks_after = 0;
    for (int i = 0; i < 8; i++) begin
      clk_cycle();
      if (s_ack) acks_after++;
    end
    checks++; if (acks_after !== 0) begin errors++; $display("FAIL rstmid_no_ack got=%0d exp=0", acks_after); end
    checks++; if (got_q.size() !== n_before) begin errors++; $display("FAIL rstmid_no_write got=%0d exp=%0d", got_q.size(), n_before); end
    checks++; if (s_rst !== 1'b0) begin errors++; $display("FAIL rstmid_fifo_reset_release got=%b exp=0", s_rst); end
    bus.fifo_almost_empty = 1'b1; clk_cycle(); bus.fifo_almost_empty = 1'b0;
    for (int i = 0; i < 4; i++) begin
      clk_cycle();
      if (s_ack) acks_after++;
    end
    checks++; if ((acks_after > 0) !== 1'b1) begin errors++; $display("FAIL rstmid_restart got=%0d exp=>0", acks_after); end
    idle_inputs(); clk_cycle(); clk_cycle();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_flush();
    test_flush_restart();
    test_burst();
    test_priority();
    test_full();
    test_back_to_back();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pcm_fifo_ctrl.md
PCM_FIFO_CTRL -- requirements
Module: pcm_fifo_ctrl

Interface
REQ-001 SHALL have parameter BURST_LEN, default 16: maximum stream bytes written per refill burst (range 1..255).
REQ-002 SHALL have parameter FLUSH_CYCLES, default 4: number of cycles fifo_reset is held on a flush.
REQ-003 SHALL have port clk, input, 1: clock.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port cpu_write, input, 1: single-cycle CPU data-register write strobe.
REQ-006 SHALL have port cpu_wrdata, input, 8: CPU sample byte.
REQ-007 SHALL have port flush_req, input, 1: single-cycle FIFO flush request.
REQ-008 SHALL have port stream_en, input, 1: enables automatic refill from the stream source.
REQ-009 SHALL have port stream_valid, input, 1: stream source has a byte.
REQ-010 SHALL have port stream_data, input, 8: stream source byte.
REQ-011 SHALL have port stream_ack, output, 1: stream byte consumed this cycle.
REQ-012 SHALL have port fifo_full, input, 1: from audio FIFO.
REQ-013 SHALL have port fifo_almost_empty, input, 1: from audio FIFO.
REQ-014 SHALL have port fifo_write, output, 1: registered FIFO write strobe.
REQ-015 SHALL have port fifo_wrdata, output, 8: registered FIFO write data.
REQ-016 SHALL have port fifo_reset, output, 1: registered FIFO reset.
REQ-017 SHALL have port busy, output, 1: high in any state other than IDLE, or while CPU pending.

Function
REQ-018 SHALL capture cpu_write/cpu_wrdata into a 1-deep pending register (cpu_pend) and SHALL NOT drop a CPU byte unless the FIFO is full when it is granted.
REQ-019 SHALL implement states IDLE, BURST, FLUSH.
REQ-020 IDLE -> BURST when stream_en && fifo_almost_empty && !fifo_full; burst counter loads 0.
REQ-021 BURST -> IDLE when counter reaches BURST_LEN, stream_en falls, or fifo_full is seen.
REQ-022 In BURST, cycles with stream_valid && !fifo_full && !cpu_pend grant the stream: stream_ack=1 (combinational), counter +1, byte written.
REQ-023 CPU pending SHALL have strict priority over the stream in every state except FLUSH; a grant clears cpu_pend the same cycle.
REQ-024 A granted byte SHALL appear on fifo_write/fifo_wrdata exactly one cycle after the grant.
REQ-025 A CPU grant when fifo_full SHALL discard the byte (no fifo_write).
REQ-026 cpu_write coincident with a CPU grant SHALL reload cpu_pend (new byte kept).
REQ-027 flush_req in any state -> FLUSH: cpu_pend cleared, burst abandoned, fifo_reset high for FLUSH_CYCLES cycles, no writes, stream_ack=0; then IDLE.
REQ-028 flush_req during FLUSH SHALL restart the flush count; cpu_write during FLUSH SHALL be ignored.

Reset
REQ-029 On rst: state IDLE, cpu_pend 0, counters 0, fifo_write 0, fifo_wrdata 0, fifo_reset 1 (asserted during rst), stream_ack 0, busy 0; asynchronous assertion mid-burst aborts it.

Configuration
REQ-030 With PCM_FIFO_OVERRUN_STAT_EN defined: add output overrun (1) and input overrun_clr (1); overrun is a sticky flag set by a REQ-025 discard, cleared by overrun_clr, or by flush, or by rst; set wins over a simultaneous clear.
REQ-031 Without PCM_FIFO_OVERRUN_STAT_EN: those ports are absent; discards are silent.

Structure
REQ-032 State encoding enum and default BURST_LEN/FLUSH_CYCLES constants SHALL live in shared package audio_pkg.
REQ-033 Single module; no sub-module required (arbiter inline).

Verification
REQ-034 Flush: pulse flush_req -> fifo_reset high exactly 4 cycles, then IDLE, busy 0.
REQ-035 Burst: stream_en=1, almost_empty=1, stream_valid always 1 -> exactly 16 stream_acks, 16 fifo_writes with matching data, then IDLE.
REQ-036 Priority: cpu_write 0xA5 mid-burst -> 0xA5 written next free slot, stream stalls one cycle, burst total still 16 stream bytes.
REQ-037 Full: fifo_full asserted at burst byte 5 -> BURST exits, 5 writes; cpu_write 0x3C while full -> no write, overrun=1 (macro defined).
REQ-038 Reset mid-burst: rst at byte 7 -> all outputs at reset values within same cycle, no further writes after release until almost_empty.
